// File: rtl/cp0_except_if.sv
// Handshake bundle between the MEM stage, CP0 and the exception sequencer.
// The sequencer is the slave; the pipeline/CP0 side is the master.
interface cp0_except_if;
    logic [5:0]  int_i;
    logic [5:0]  int_sync_o;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_ds_i;
    logic [31:0] mem_bad_addr_i;
    logic        exc_adel_if_i;
    logic        exc_ri_i;
    logic        exc_ov_i;
    logic        exc_trap_i;
    logic        exc_sys_i;
    logic        exc_bp_i;
    logic        exc_adel_i;
    logic        exc_ades_i;
    logic        eret_i;
    logic        stall_i;
    logic        hold_o;
    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_in_ds_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    modport master (
        output int_i, status_i, cause_i, epc_i, mem_valid_i, mem_pc_i, mem_in_ds_i,
               mem_bad_addr_i, exc_adel_if_i, exc_ri_i, exc_ov_i, exc_trap_i, exc_sys_i,
               exc_bp_i, exc_adel_i, exc_ades_i, eret_i, stall_i,
        input  int_sync_o, hold_o, excepttype_o, exc_pc_o, exc_in_ds_o, bad_addr_o,
               flush_o, redirect_o, redirect_pc_o, busy_o
    );

    modport slave (
        input  int_i, status_i, cause_i, epc_i, mem_valid_i, mem_pc_i, mem_in_ds_i,
               mem_bad_addr_i, exc_adel_if_i, exc_ri_i, exc_ov_i, exc_trap_i, exc_sys_i,
               exc_bp_i, exc_adel_i, exc_ades_i, eret_i, stall_i,
        output int_sync_o, hold_o, excepttype_o, exc_pc_o, exc_in_ds_o, bad_addr_o,
               flush_o, redirect_o, redirect_pc_o, busy_o
    );
endinterface

// File: rtl/cp0_except_ctrl.sv
// Exception/interrupt sequencer: resolves MEM-stage exceptions by priority, commits them to
// CP0 for one cycle, then flushes the pipeline and redirects the PC.
module cp0_except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input logic         clk,
    input logic         rst,
    cp0_except_if.slave bus
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StCommit, StFlush} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [5:0]        sync_q [SYNC_STAGES];
    logic [4:0]        code, code_q;
    logic [31:0]       bad, bad_q;
    logic [31:0]       pc_q;
    logic              ds_q;
    logic              int_take, any_exc, detect, take;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.int_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign bus.int_sync_o = sync_q[SYNC_STAGES-1];

    // IE set, EXL clear, and some pending line unmasked.
    assign int_take = bus.status_i[0] & ~bus.status_i[1] &
                      (|(bus.cause_i[15:8] & bus.status_i[15:8]));

    logic unused_bits;
    assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                           bus.cause_i[31:16], bus.cause_i[7:0]};

    always_comb begin
        code    = 5'h00;
        bad     = 32'h0;
        any_exc = 1'b1;
        if (int_take) begin
            code = 5'h01;
        end else if (bus.exc_adel_if_i) begin
            code = 5'h04;
            bad  = bus.mem_pc_i;
        end else if (bus.exc_ri_i) begin
            code = 5'h0a;
        end else if (bus.exc_ov_i) begin
            code = 5'h0c;
        end else if (bus.exc_trap_i) begin
            code = 5'h0d;
        end else if (bus.exc_sys_i) begin
            code = 5'h08;
        end else if (bus.exc_bp_i) begin
            code = 5'h09;
        end else if (bus.exc_adel_i) begin
            code = 5'h04;
            bad  = bus.mem_bad_addr_i;
        end else if (bus.exc_ades_i) begin
            code = 5'h05;
            bad  = bus.mem_bad_addr_i;
        end else if (bus.eret_i) begin
            code = 5'h0e;
        end else begin
            any_exc = 1'b0;
        end
    end

    assign detect = bus.mem_valid_i & any_exc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (detect && !bus.stall_i) begin
                    take    = 1'b1;
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (FLUSH_CYCLES > 0) begin
                    state_d = StFlush;
                    cnt_d   = CntW'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= '0;
            bad_q   <= '0;
            pc_q    <= '0;
            ds_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                code_q <= code;
                bad_q  <= bad;
                pc_q   <= bus.mem_pc_i;
                ds_q   <= bus.mem_in_ds_i;
            end
        end
    end

    logic commit;
    assign commit = (state_q == StCommit);

    assign bus.hold_o        = take;
    assign bus.excepttype_o  = commit ? {27'h0, code_q} : 32'h0;
    assign bus.exc_pc_o      = commit ? pc_q : 32'h0;
    assign bus.exc_in_ds_o   = commit & ds_q;
    assign bus.bad_addr_o    = commit ? bad_q : 32'h0;
    assign bus.flush_o       = commit | (state_q == StFlush);
    assign bus.redirect_o    = commit;
    // ERET returns to EPC; everything else goes to the common vector.
    assign bus.redirect_pc_o = !commit ? 32'h0 : (code_q == 5'h0e) ? bus.epc_i : EXC_VECTOR;
    assign bus.busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed bench for cp0_except_ctrl; CP0 Cause is modelled as reflecting int_sync_o.
module tb_cp0_except_ctrl;

    localparam logic [31:0] Vec = 32'hBFC00380;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    cp0_except_if bus ();

    cp0_except_ctrl #(
        .EXC_VECTOR   (Vec),
        .FLUSH_CYCLES (1),
        .SYNC_STAGES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.cause_i = {16'h0, bus.int_sync_o, 10'h0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.int_i          = '0;
        bus.mem_valid_i    = 1'b0;
        bus.mem_in_ds_i    = 1'b0;
        bus.exc_adel_if_i  = 1'b0;
        bus.exc_ri_i       = 1'b0;
        bus.exc_ov_i       = 1'b0;
        bus.exc_trap_i     = 1'b0;
        bus.exc_sys_i      = 1'b0;
        bus.exc_bp_i       = 1'b0;
        bus.exc_adel_i     = 1'b0;
        bus.exc_ades_i     = 1'b0;
        bus.eret_i         = 1'b0;
        bus.stall_i        = 1'b0;
    endtask

    // Inputs already present for a detect; walks commit, flush, back to idle.
    task automatic fire(input string tag, input logic [31:0] code, input logic [31:0] pc,
                        input logic ds, input logic [31:0] bad, input logic [31:0] rpc);
        #1;
        chk({tag, ".hold"}, 32'(bus.hold_o), 32'd1);
        step();
        chk({tag, ".code"}, bus.excepttype_o, code);
        chk({tag, ".pc"}, bus.exc_pc_o, pc);
        chk({tag, ".ds"}, 32'(bus.exc_in_ds_o), 32'(ds));
        chk({tag, ".bad"}, bus.bad_addr_o, bad);
        chk({tag, ".rpc"}, bus.redirect_pc_o, rpc);
        chk({tag, ".flush_c"}, {30'h0, bus.flush_o, bus.redirect_o}, 32'h3);
        clear_in();
        step();
        chk({tag, ".flush_f"}, {29'h0, bus.flush_o, bus.redirect_o, bus.busy_o}, 32'h5);
        chk({tag, ".code_f"}, bus.excepttype_o, 32'h0);
        step();
        chk({tag, ".idle"}, {30'h0, bus.flush_o, bus.busy_o}, 32'h0);
    endtask

    initial begin
        rst                = 1'b1;
        bus.status_i       = 32'h0;
        bus.epc_i          = 32'h0;
        bus.mem_pc_i       = 32'h0;
        bus.mem_bad_addr_i = 32'h0;
        clear_in();
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst.flags", {28'h0, bus.flush_o, bus.redirect_o, bus.busy_o, bus.hold_o}, 32'h0);
        chk("rst.code", bus.excepttype_o, 32'h0);
        chk("rst.rpc", bus.redirect_pc_o, 32'h0);
        chk("rst.sync", 32'(bus.int_sync_o), 32'h0);

        // Syscall.
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i    = 32'hBFC00100;
        bus.exc_sys_i   = 1'b1;
        fire("sys", 32'h08, 32'hBFC00100, 1'b0, 32'h0, Vec);

        // Overflow outranks load address error.
        bus.mem_valid_i    = 1'b1;
        bus.mem_pc_i       = 32'hBFC00110;
        bus.mem_bad_addr_i = 32'h80000003;
        bus.exc_adel_i     = 1'b1;
        bus.exc_ov_i       = 1'b1;
        fire("ov", 32'h0c, 32'hBFC00110, 1'b0, 32'h0, Vec);
        bus.mem_valid_i = 1'b1;
        bus.exc_adel_i  = 1'b1;
        fire("adel", 32'h04, 32'hBFC00110, 1'b0, 32'h80000003, Vec);

        // Fetch address error beats RI; delay slot flag and BadVAddr=PC.
        bus.mem_valid_i   = 1'b1;
        bus.mem_pc_i      = 32'hBFC00202;
        bus.mem_in_ds_i   = 1'b1;
        bus.exc_adel_if_i = 1'b1;
        bus.exc_ri_i      = 1'b1;
        fire("adelif", 32'h04, 32'hBFC00202, 1'b1, 32'hBFC00202, Vec);

        // Store address error.
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i    = 32'hBFC00120;
        bus.exc_ades_i  = 1'b1;
        fire("ades", 32'h05, 32'hBFC00120, 1'b0, 32'h80000003, Vec);

        // Bubble with a flag: nothing happens.
        bus.exc_sys_i = 1'b1;
        #1;
        chk("bubble.hold", 32'(bus.hold_o), 32'h0);
        step();
        chk("bubble.busy", 32'(bus.busy_o), 32'h0);
        clear_in();

        // Interrupt via synchroniser.
        bus.status_i    = 32'h00000401;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i    = 32'hBFC00130;
        bus.int_i       = 6'h01;
        step();
        chk("int.sync1", 32'(bus.int_sync_o), 32'h0);
        chk("int.hold1", 32'(bus.hold_o), 32'h0);
        step();
        chk("int.sync2", 32'(bus.int_sync_o), 32'h1);
        fire("int", 32'h01, 32'hBFC00130, 1'b0, 32'h0, Vec);
        step();
        step();
        step();

        // EXL set: interrupt masked.
        bus.status_i    = 32'h00000403;
        bus.mem_valid_i = 1'b1;
        bus.int_i       = 6'h01;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("exl.busy", {30'h0, bus.busy_o, bus.hold_o}, 32'h0);
        end
        chk("exl.sync", 32'(bus.int_sync_o), 32'h1);
        clear_in();
        bus.status_i = 32'h0;
        step();
        step();
        step();

        // ERET redirects to EPC.
        bus.epc_i       = 32'hBFC00404;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i    = 32'hBFC00140;
        bus.eret_i      = 1'b1;
        fire("eret", 32'h0e, 32'hBFC00140, 1'b0, 32'h0, 32'hBFC00404);

        // Stall defers the commit.
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i    = 32'hBFC00150;
        bus.exc_sys_i   = 1'b1;
        bus.stall_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.hold", 32'(bus.hold_o), 32'h0);
            step();
            chk("stall.code", bus.excepttype_o, 32'h0);
            chk("stall.busy", 32'(bus.busy_o), 32'h0);
        end
        bus.stall_i = 1'b0;
        fire("stall", 32'h08, 32'hBFC00150, 1'b0, 32'h0, Vec);

        // Reset during FLUSH.
        bus.mem_valid_i = 1'b1;
        bus.exc_sys_i   = 1'b1;
        #1;
        step();
        clear_in();
        step();
        chk("rstf.pre", 32'(bus.flush_o), 32'h1);
        rst = 1'b1;
        step();
        chk("rstf.flags", {29'h0, bus.flush_o, bus.redirect_o, bus.busy_o}, 32'h0);
        chk("rstf.code", bus.excepttype_o, 32'h0);
        chk("rstf.pc", bus.exc_pc_o, 32'h0);
        rst = 1'b0;

        // Reset during COMMIT.
        bus.mem_valid_i = 1'b1;
        bus.exc_sys_i   = 1'b1;
        #1;
        step();
        chk("rstc.pre", 32'(bus.redirect_o), 32'h1);
        clear_in();
        rst = 1'b1;
        step();
        chk("rstc.flags", {29'h0, bus.flush_o, bus.redirect_o, bus.busy_o}, 32'h0);
        chk("rstc.rpc", bus.redirect_pc_o, 32'h0);
        rst = 1'b0;
        step();
        chk("rstc.after", {30'h0, bus.flush_o, bus.busy_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
